// File: rtl/imem_arbiter_if.sv
// Request/response and memory-port signals shared by the two refill engines and the arbiter.
// slave = arbiter side; master = requesters plus backing memory.
interface imem_arbiter_if #(
    parameter int WORD_SIZE = 32
);
    logic                 req0Valid;
    logic [31:0]          req0Address;
    logic [WORD_SIZE-1:0] resp0Data;
    logic                 resp0Ready;
    logic                 resp0Last;

    logic                 req1Valid;
    logic [31:0]          req1Address;
    logic [WORD_SIZE-1:0] resp1Data;
    logic                 resp1Ready;
    logic                 resp1Last;

    logic                 memReadRequest;
    logic [31:0]          memReadAddress;
    logic [WORD_SIZE-1:0] memDataIn;
    logic                 memDataReady;

    modport slave (
        input  req0Valid, req0Address, req1Valid, req1Address, memDataIn, memDataReady,
        output resp0Data, resp0Ready, resp0Last, resp1Data, resp1Ready, resp1Last,
               memReadRequest, memReadAddress
    );

    modport master (
        output req0Valid, req0Address, req1Valid, req1Address, memDataIn, memDataReady,
        input  resp0Data, resp0Ready, resp0Last, resp1Data, resp1Ready, resp1Last,
               memReadRequest, memReadAddress
    );
endinterface

// File: rtl/imem_arbiter.sv
// Round-robin arbiter sharing one block-burst memory read port between two refill engines.
// Strobe one cycle after grant, beats forwarded with no latency; losers hold reqValid until the next IDLE.
module imem_arbiter #(
    parameter int BLOCK_WORDS = 4,
    parameter int WORD_SIZE   = 32
) (
    input  logic           clk,
    input  logic           reset,
    imem_arbiter_if.slave  bus,
    output logic           busy,
    output logic           grantId,
    output logic           protocolError
);
    localparam int                BEAT_W    = $clog2(BLOCK_WORDS);
    localparam int                OFF_W     = $clog2(BLOCK_WORDS * 4);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BLOCK_WORDS - 1);
    localparam logic [31:0]       ADDR_MASK = ~((32'd1 << OFF_W) - 32'd1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              grant_q, grant_d;
    logic              last_grant_q, last_grant_d;
    logic [31:0]       addr_q, addr_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic              mem_req_q;
    logic              busy_q;
    logic              perr_q, perr_d;
    logic              pick;
    logic              beat_vld;

    assign beat_vld = (state_q == WAIT) && bus.memDataReady;
    // A tie goes to whoever did not win last time; otherwise the lone requester wins.
    assign pick     = (bus.req0Valid && bus.req1Valid) ? ~last_grant_q : bus.req1Valid;

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        beat_d       = beat_q;
        perr_d       = perr_q | (bus.memDataReady && (state_q != WAIT));
        case (state_q)
            IDLE: begin
                if (bus.req0Valid || bus.req1Valid) begin
                    state_d      = ISSUE;
                    grant_d      = pick;
                    last_grant_d = pick;
                    addr_d       = (pick ? bus.req1Address : bus.req0Address) & ADDR_MASK;
                end
            end
            ISSUE: begin
                state_d = WAIT;
                beat_d  = '0;
            end
            WAIT: begin
                if (beat_vld) begin
                    beat_d = beat_q + 1'b1;
                    if (beat_q == LAST_BEAT) begin
                        state_d = DONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            addr_q       <= '0;
            beat_q       <= '0;
            mem_req_q    <= 1'b0;
            busy_q       <= 1'b0;
            perr_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            beat_q       <= beat_d;
            mem_req_q    <= (state_d == ISSUE);
            busy_q       <= (state_d != IDLE);
            perr_q       <= perr_d;
        end
    end

    assign bus.memReadRequest = mem_req_q;
    assign bus.memReadAddress = addr_q;
    assign bus.resp0Data      = bus.memDataIn;
    assign bus.resp1Data      = bus.memDataIn;
    assign bus.resp0Ready     = beat_vld && !grant_q;
    assign bus.resp1Ready     = beat_vld &&  grant_q;
    assign bus.resp0Last      = bus.resp0Ready && (beat_q == LAST_BEAT);
    assign bus.resp1Last      = bus.resp1Ready && (beat_q == LAST_BEAT);

    assign busy          = busy_q;
    assign grantId       = grant_q;
    assign protocolError = perr_q;
endmodule

// File: tb/tb_imem_arbiter.sv
// Randomized bench for imem_arbiter with a requester/memory model and a round-robin reference.
// Inputs change 2 time units after each rising edge; outputs are sampled 1 unit later.
module tb_imem_arbiter;
    logic clk;
    logic reset;
    logic busy, grantId, protocolError;

    imem_arbiter_if #(.WORD_SIZE(32)) bus();

    imem_arbiter #(.BLOCK_WORDS(4), .WORD_SIZE(32)) dut (
        .clk           (clk),
        .reset         (reset),
        .bus           (bus),
        .busy          (busy),
        .grantId       (grantId),
        .protocolError (protocolError)
    );

    int          checks = 0;
    int          errors = 0;
    logic        tb_last;
    logic        tb_perr;
    logic [31:0] a0, a1;
    logic        grants[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic apply_reset();
        reset                = 1'b0;
        bus.req0Valid        = 1'b0;
        bus.req1Valid        = 1'b0;
        bus.req0Address      = '0;
        bus.req1Address      = '0;
        bus.memDataIn        = '0;
        bus.memDataReady     = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        reset   = 1'b1;
        tb_last = 1'b1;
        tb_perr = 1'b0;
    endtask

    // Acts as memory for one burst: waits for the strobe, then returns 4 beats with random gaps.
    task automatic serve(input int gap_min, input int gap_max, input bit keep, input bit rnd_data,
                         input logic [31:0] dbase, input int abort_after, output int wait_cycles);
        int          n, g;
        logic        exp_g, exp_last;
        logic [31:0] exp_addr, d, got_data;
        logic        got_rdy, oth_rdy, got_last, oth_last;
        exp_g    = (bus.req0Valid && bus.req1Valid) ? ~tb_last : bus.req1Valid;
        exp_addr = exp_g ? a1 : a0;
        exp_addr = exp_addr - (exp_addr % 32'd16);
        n = 0;
        do begin
            step();
            #1;
            n++;
        end while (bus.memReadRequest !== 1'b1 && n < 20);
        wait_cycles = n;
        checks++;
        if (bus.memReadRequest !== 1'b1) begin
            errors++;
            $display("FAIL issue_timeout memReadRequest=%b after %0d cycles, required 1", bus.memReadRequest, n);
            return;
        end
        checks++;
        if (grantId !== exp_g) begin
            errors++;
            $display("FAIL grant grantId=%b required %b", grantId, exp_g);
        end
        checks++;
        if (bus.memReadAddress !== exp_addr) begin
            errors++;
            $display("FAIL address memReadAddress=%h required %h", bus.memReadAddress, exp_addr);
        end
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_issue busy=%b required 1", busy);
        end
        tb_last = exp_g;
        grants.push_back(exp_g);
        for (int b = 0; b < 4; b++) begin
            g = int'($urandom_range(gap_max, gap_min));
            for (int i = 0; i < g; i++) begin
                step();
                bus.memDataReady = 1'b0;
                #1;
                checks++;
                if ({bus.resp0Ready, bus.resp1Ready, bus.memReadRequest, busy} !== 4'b0001) begin
                    errors++;
                    $display("FAIL gap_cycle ready0/ready1/memReq/busy=%b%b%b%b required 0001",
                             bus.resp0Ready, bus.resp1Ready, bus.memReadRequest, busy);
                end
            end
            step();
            d = rnd_data ? $urandom : dbase + 32'(b);
            bus.memDataIn    = d;
            bus.memDataReady = 1'b1;
            #1;
            exp_last = (b == 3);
            got_rdy  = exp_g ? bus.resp1Ready : bus.resp0Ready;
            oth_rdy  = exp_g ? bus.resp0Ready : bus.resp1Ready;
            got_last = exp_g ? bus.resp1Last  : bus.resp0Last;
            oth_last = exp_g ? bus.resp0Last  : bus.resp1Last;
            got_data = exp_g ? bus.resp1Data  : bus.resp0Data;
            checks++;
            if ({got_rdy, oth_rdy, got_last, oth_last, bus.memReadRequest} !== {1'b1, 1'b0, exp_last, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL beat%0d rdy/oth_rdy/last/oth_last/memReq=%b%b%b%b%b required 10%b00",
                         b, got_rdy, oth_rdy, got_last, oth_last, bus.memReadRequest, exp_last);
            end
            checks++;
            if (got_data !== d) begin
                errors++;
                $display("FAIL beat%0d_data got %h required %h", b, got_data, d);
            end
            if (abort_after == b + 1) return;
        end
        step();
        bus.memDataReady = 1'b0;
        if (!keep) begin
            if (exp_g) bus.req1Valid = 1'b0;
            else       bus.req0Valid = 1'b0;
        end
        #1;
        checks++;
        if ({busy, bus.resp0Ready, bus.resp1Ready} !== 3'b100) begin
            errors++;
            $display("FAIL done_gap busy/ready0/ready1=%b%b%b required 100", busy, bus.resp0Ready, bus.resp1Ready);
        end
        checks++;
        if (protocolError !== tb_perr) begin
            errors++;
            $display("FAIL perr_after_burst protocolError=%b required %b", protocolError, tb_perr);
        end
    endtask

    task automatic test_reset();
        reset            = 1'b0;
        bus.memDataReady = 1'b1;
        bus.req0Valid    = 1'b1;
        #3;
        checks++;
        if ({bus.memReadRequest, busy, grantId, protocolError} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctrl memReq/busy/grant/perr=%b%b%b%b required 0000",
                     bus.memReadRequest, busy, grantId, protocolError);
        end
        checks++;
        if (bus.memReadAddress !== 32'h0) begin
            errors++;
            $display("FAIL reset_addr memReadAddress=%h required 0", bus.memReadAddress);
        end
        checks++;
        if ({bus.resp0Ready, bus.resp0Last, bus.resp1Ready, bus.resp1Last} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_resp r0/l0/r1/l1=%b%b%b%b required 0000",
                     bus.resp0Ready, bus.resp0Last, bus.resp1Ready, bus.resp1Last);
        end
        apply_reset();
        #1;
        checks++;
        if ({busy, protocolError} !== 2'b00) begin
            errors++;
            $display("FAIL reset_release busy/perr=%b%b required 00", busy, protocolError);
        end
    endtask

    task automatic test_single();
        int n;
        a0 = 32'h0000_0124;
        bus.req0Address = a0;
        bus.req0Valid   = 1'b1;
        serve(0, 0, 1'b0, 1'b0, 32'hA0, 0, n);
        checks++;
        if (n !== 1) begin
            errors++;
            $display("FAIL single_latency strobe after %0d cycles, required 1", n);
        end
    endtask

    task automatic test_simultaneous();
        int n0, n1;
        apply_reset();
        a0 = $urandom;
        a1 = $urandom;
        bus.req0Address = a0;
        bus.req1Address = a1;
        bus.req0Valid   = 1'b1;
        bus.req1Valid   = 1'b1;
        serve(0, 1, 1'b0, 1'b1, 32'h0, 0, n0);
        serve(0, 1, 1'b0, 1'b1, 32'h0, 0, n1);
        checks++;
        if (n0 !== 1 || n1 !== 2) begin
            errors++;
            $display("FAIL simul_timing strobe gaps %0d,%0d required 1,2", n0, n1);
        end
        checks++;
        if (grants.size() < 2 || grants[grants.size()-2] !== 1'b0 || grants[grants.size()-1] !== 1'b1) begin
            errors++;
            $display("FAIL simul_order grant history size %0d, required ... 0 then 1", grants.size());
        end
    endtask

    task automatic test_round_robin();
        int n;
        int base;
        a0 = $urandom;
        a1 = $urandom;
        bus.req0Address = a0;
        bus.req1Address = a1;
        bus.req0Valid   = 1'b1;
        bus.req1Valid   = 1'b1;
        base = grants.size();
        for (int k = 0; k < 4; k++) begin
            serve(0, 2, 1'b1, 1'b1, 32'h0, 0, n);
            if (k > 0) begin
                checks++;
                if (n !== 2) begin
                    errors++;
                    $display("FAIL rr_gap burst %0d strobe after %0d cycles, required 2", k, n);
                end
            end
        end
        bus.req0Valid = 1'b0;
        bus.req1Valid = 1'b0;
        for (int k = base + 1; k < grants.size(); k++) begin
            checks++;
            if (grants[k] === grants[k-1]) begin
                errors++;
                $display("FAIL rr_alternate burst %0d repeated grant %b", k - base, grants[k]);
            end
        end
    endtask

    task automatic test_gapped();
        int n;
        a0 = $urandom;
        bus.req0Address = a0;
        bus.req0Valid   = 1'b1;
        serve(2, 2, 1'b0, 1'b1, 32'h0, 0, n);
        step();
        #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL gapped_release busy=%b required 0", busy);
        end
    endtask

    task automatic test_stray();
        int n;
        repeat (2) step();
        bus.memDataReady = 1'b1;
        bus.memDataIn    = $urandom;
        #1;
        checks++;
        if ({bus.resp0Ready, bus.resp1Ready} !== 2'b00) begin
            errors++;
            $display("FAIL stray_forward ready0/ready1=%b%b required 00", bus.resp0Ready, bus.resp1Ready);
        end
        step();
        bus.memDataReady = 1'b0;
        #1;
        tb_perr = 1'b1;
        checks++;
        if (protocolError !== 1'b1) begin
            errors++;
            $display("FAIL stray_flag protocolError=%b required 1", protocolError);
        end
        a1 = $urandom;
        bus.req1Address = a1;
        bus.req1Valid   = 1'b1;
        serve(0, 1, 1'b0, 1'b1, 32'h0, 0, n);
        apply_reset();
        #1;
        checks++;
        if (protocolError !== 1'b0) begin
            errors++;
            $display("FAIL stray_clear protocolError=%b required 0", protocolError);
        end
    endtask

    task automatic test_midreset();
        int n;
        a1 = $urandom;
        bus.req1Address = a1;
        bus.req1Valid   = 1'b1;
        serve(0, 1, 1'b0, 1'b1, 32'h0, 2, n);
        reset = 1'b0;
        #1;
        checks++;
        if ({busy, bus.memReadRequest, bus.resp1Ready, bus.resp1Last, grantId} !== 5'b00000) begin
            errors++;
            $display("FAIL midreset_async busy/memReq/r1/l1/grant=%b%b%b%b%b required 00000",
                     busy, bus.memReadRequest, bus.resp1Ready, bus.resp1Last, grantId);
        end
        checks++;
        if (bus.memReadAddress !== 32'h0) begin
            errors++;
            $display("FAIL midreset_addr memReadAddress=%h required 0", bus.memReadAddress);
        end
        bus.memDataReady = 1'b0;
        @(posedge clk);
        #2;
        reset   = 1'b1;
        tb_last = 1'b1;
        tb_perr = 1'b0;
        serve(0, 2, 1'b0, 1'b1, 32'h0, 0, n);
        checks++;
        if (n !== 1) begin
            errors++;
            $display("FAIL midreset_regrant strobe after %0d cycles, required 1", n);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_simultaneous();
        test_round_robin();
        test_gapped();
        test_stray();
        test_midreset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
